// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DFLT_CNT_W = 27;
  // Terminal count giving 1 kHz from a 100 MHz board clock.
  localparam int unsigned DFLT_HALF  = 49_999;
  localparam int unsigned MAX_CH     = 16;

  typedef logic [DFLT_CNT_W-1:0] cnt_t;

  // The channel index must be able to encode N_CH itself, otherwise an out-of-range
  // request could never be presented and the error path would be unreachable.
  function automatic int unsigned ch_idx_w(int unsigned n_ch);
    return (n_ch < 1) ? 1 : $clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration port of clk_div_multi: valid/ready request plus a one-cycle error pulse.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = DFLT_CNT_W
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_half,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, terminal count, pending reload and registered clk/tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = DFLT_CNT_W,
  parameter int unsigned DEFAULT_HALF = DFLT_HALF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  output logic             pending,
  output logic             div_clk,
  output logic             tick
);

  logic [CNT_W-1:0] ctr_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] pend_half_q;
  logic             pend_q;
  logic             clk_q;
  logic             tick_q;

  // Count to the terminal value, toggle, and swap in a pending terminal count only at a
  // toggle (or while held idle) so the running half-period never gets cut short.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctr_q       <= '0;
      half_q      <= CNT_W'(DEFAULT_HALF);
      pend_half_q <= '0;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (sync || !en) begin
        ctr_q <= '0;
        clk_q <= 1'b0;
        if (pend_q) begin
          half_q <= pend_half_q;
          pend_q <= 1'b0;
        end
      end else if (ctr_q == half_q) begin
        ctr_q  <= '0;
        clk_q  <= !clk_q;
        tick_q <= !clk_q;
        if (pend_q) begin
          half_q <= pend_half_q;
          pend_q <= 1'b0;
        end
      end else begin
        ctr_q <= ctr_q + CNT_W'(1);
      end
      // load is only issued while pend_q is low, so it never races the apply above.
      if (load) begin
        pend_q      <= 1'b1;
        pend_half_q <= load_half;
      end
    end
  end

  assign pending = pend_q;
  assign div_clk = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator with runtime divisor reload.
// Optional feature macro: CLK_DIV_SYNC_EN adds sync_i, which phase-aligns all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = DFLT_CNT_W,
  parameter int unsigned DEFAULT_HALF = DFLT_HALF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] en_i,
`ifdef CLK_DIV_SYNC_EN
  input  logic            sync_i,
`endif
  clk_div_multi_if.slave  cfg,
  output logic [N_CH-1:0] clk_o,
  output logic [N_CH-1:0] tick_o
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] load;
  logic            in_range;
  logic            accept;
  logic            err_q;
  logic            sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // One-hot decode of the target channel; all zeros means out of range.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = (cfg.cfg_ch == CH_W'(c));
    end
  end

  assign in_range      = |hit;
  // Independent of cfg_valid; out-of-range requests are always ready so they can be dropped.
  assign cfg.cfg_ready = !(|(hit & pend));
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign load          = {N_CH{accept}} & hit;

  // Flag a dropped out-of-range request for exactly one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
    end
  end

  assign cfg.cfg_err = err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en        (en_i[c]),
      .sync      (sync),
      .load      (load[c]),
      .load_half (cfg.cfg_half),
      .pending   (pend[c]),
      .div_clk   (clk_o[c]),
      .tick      (tick_o[c])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (reduced DEFAULT_HALF to keep runs short).
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 27;
  localparam int unsigned DHALF = 999;

  logic            clk_i;
  logic            reset_i;
  logic [N_CH-1:0] en_i;
  logic [N_CH-1:0] clk_o;
  logic [N_CH-1:0] tick_o;
`ifdef CLK_DIV_SYNC_EN
  logic            sync_i;
`endif

  int checks;
  int failures;

  clk_div_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_if ();

  clk_div_multi #(
    .N_CH         (N_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DHALF)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (en_i),
`ifdef CLK_DIV_SYNC_EN
    .sync_i  (sync_i),
`endif
    .cfg     (cfg_if),
    .clk_o   (clk_o),
    .tick_o  (tick_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    en_i = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_half = '0;
`ifdef CLK_DIV_SYNC_EN
    sync_i = 1'b0;
`endif
    repeat (3) step();
    checks++;
    if (clk_o !== 4'b0000) begin
      failures++; $display("FAIL reset_clk got=%b want=0000", clk_o);
    end
    checks++;
    if (tick_o !== 4'b0000) begin
      failures++; $display("FAIL reset_tick got=%b want=0000", tick_o);
    end
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b want=0", cfg_if.cfg_err);
    end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", cfg_if.cfg_ready);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_default();
    int nt = 0;
    int tt[2] = '{0, 0};
    int fall = 0;
    int bad_tick = 0;
    logic prev = 1'b0;
    en_i = 4'b0001;
    for (int k = 1; k <= 3005; k++) begin
      step();
      if (tick_o[0] === 1'b1) begin
        if (nt < 2) tt[nt] = k;
        nt++;
        if (prev !== 1'b0 || clk_o[0] !== 1'b1) bad_tick++;
      end
      if (prev === 1'b1 && clk_o[0] === 1'b0 && fall == 0) fall = k;
      prev = clk_o[0];
    end
    checks++;
    if (nt != 2) begin
      failures++; $display("FAIL default_tick_count got=%0d want=2", nt);
    end
    checks++;
    if (tt[0] != 1000) begin
      failures++; $display("FAIL default_first_rise got=%0d want=1000", tt[0]);
    end
    checks++;
    if (tt[1] != 3000) begin
      failures++; $display("FAIL default_second_rise got=%0d want=3000", tt[1]);
    end
    checks++;
    if (fall != 2000) begin
      failures++; $display("FAIL default_fall got=%0d want=2000", fall);
    end
    checks++;
    if (bad_tick != 0) begin
      failures++; $display("FAIL default_tick_align got=%0d want=0", bad_tick);
    end
    checks++;
    if (clk_o[3:1] !== 3'b000) begin
      failures++; $display("FAIL default_idle_ch got=%b want=000", clk_o[3:1]);
    end
    en_i = 4'b0000;
    step();
  endtask

  task automatic test_reprogram();
    int nt = 0;
    int tt[3] = '{0, 0, 0};
    int stall_bad = 0;
    en_i = 4'b0010;
    for (int k = 1; k <= 1025; k++) begin
      step();
      if (tick_o[1] === 1'b1) begin
        if (nt < 3) tt[nt] = k;
        nt++;
      end
      if (k == 300) begin
        cfg_if.cfg_ch = 3'd1;
        cfg_if.cfg_half = 27'd4;
        cfg_if.cfg_valid = 1'b1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          failures++; $display("FAIL reprog_ready_before got=%b want=1", cfg_if.cfg_ready);
        end
      end
      if (k == 301) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          failures++; $display("FAIL reprog_ready_pending got=%b want=0", cfg_if.cfg_ready);
        end
        cfg_if.cfg_half = 27'd7;
      end
      if (k >= 302 && k <= 306 && cfg_if.cfg_ready !== 1'b0) stall_bad++;
      if (k == 306) cfg_if.cfg_valid = 1'b0;
      if (k == 999) begin
        checks++;
        if (clk_o[1] !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL reprog_old_half clk=%b ready=%b want clk=0 ready=0",
                   clk_o[1], cfg_if.cfg_ready);
        end
      end
      if (k == 1000) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          failures++; $display("FAIL reprog_ready_after got=%b want=1", cfg_if.cfg_ready);
        end
      end
      if (k == 1004 || k == 1005) begin
        checks++;
        if (clk_o[1] !== (k == 1004)) begin
          failures++; $display("FAIL reprog_fall_k%0d got=%b want=%b", k, clk_o[1], k == 1004);
        end
      end
    end
    checks++;
    if (stall_bad != 0) begin
      failures++; $display("FAIL reprog_stall got=%0d want=0", stall_bad);
    end
    checks++;
    if (tt[0] != 1000 || tt[1] != 1010 || tt[2] != 1020) begin
      failures++;
      $display("FAIL reprog_ticks got=%0d,%0d,%0d want=1000,1010,1020", tt[0], tt[1], tt[2]);
    end
    en_i = 4'b0000;
    step();
  endtask

  task automatic test_t0();
    cfg_if.cfg_ch = 3'd2;
    cfg_if.cfg_half = 27'd0;
    cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL t0_pending got=%b want=0", cfg_if.cfg_ready);
    end
    step();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL t0_applied_idle got=%b want=1", cfg_if.cfg_ready);
    end
    en_i = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (clk_o[2] !== k[0] || tick_o[2] !== k[0]) begin
        failures++;
        $display("FAIL t0_cycle%0d clk=%b tick=%b want=%b", k, clk_o[2], tick_o[2], k[0]);
      end
    end
  endtask

  task automatic test_error();
    logic c2;
    cfg_if.cfg_ch = 3'd4;
    cfg_if.cfg_half = 27'd11;
    cfg_if.cfg_valid = 1'b1;
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL err_ready got=%b want=1", cfg_if.cfg_ready);
    end
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_err !== 1'b1) begin
      failures++; $display("FAIL err_pulse got=%b want=1", cfg_if.cfg_err);
    end
    c2 = clk_o[2];
    step();
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      failures++; $display("FAIL err_one_cycle got=%b want=0", cfg_if.cfg_err);
    end
    checks++;
    if (clk_o[2] !== ~c2) begin
      failures++; $display("FAIL err_ch2_unchanged got=%b want=%b", clk_o[2], ~c2);
    end
    for (int c = 0; c < 4; c++) begin
      cfg_if.cfg_ch = 3'(c);
      #1;
      checks++;
      if (cfg_if.cfg_ready !== 1'b1) begin
        failures++; $display("FAIL err_no_pending_ch%0d got=%b want=1", c, cfg_if.cfg_ready);
      end
    end
  endtask

  task automatic test_enable();
    en_i[3] = 1'b1;
    repeat (1000) step();
    checks++;
    if (clk_o[3] !== 1'b1 || tick_o[3] !== 1'b1) begin
      failures++; $display("FAIL en_first_rise clk=%b tick=%b want=1,1", clk_o[3], tick_o[3]);
    end
    repeat (500) step();
    en_i[3] = 1'b0;
    step();
    checks++;
    if (clk_o[3] !== 1'b0 || tick_o[3] !== 1'b0) begin
      failures++; $display("FAIL en_drop clk=%b tick=%b want=0,0", clk_o[3], tick_o[3]);
    end
    repeat (5) step();
    checks++;
    if (clk_o[3] !== 1'b0) begin
      failures++; $display("FAIL en_held got=%b want=0", clk_o[3]);
    end
    en_i[3] = 1'b1;
    repeat (999) step();
    checks++;
    if (clk_o[3] !== 1'b0) begin
      failures++; $display("FAIL en_restart_early got=%b want=0", clk_o[3]);
    end
    step();
    checks++;
    if (clk_o[3] !== 1'b1 || tick_o[3] !== 1'b1) begin
      failures++; $display("FAIL en_restart_rise clk=%b tick=%b want=1,1", clk_o[3], tick_o[3]);
    end
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    en_i[0] = 1'b1;
    repeat (237) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checks++;
    if (clk_o !== 4'b0000) begin
      failures++; $display("FAIL sync_clear got=%b want=0000", clk_o);
    end
    step();
    checks++;
    if (clk_o[2] !== 1'b1) begin
      failures++; $display("FAIL sync_ch2_rise got=%b want=1", clk_o[2]);
    end
    repeat (998) step();
    checks++;
    if (clk_o[0] !== 1'b0 || clk_o[3] !== 1'b0) begin
      failures++; $display("FAIL sync_early got=%b want=0x0", clk_o);
    end
    step();
    checks++;
    if (clk_o[0] !== 1'b1 || clk_o[3] !== 1'b1 || tick_o[0] !== 1'b1 || tick_o[3] !== 1'b1) begin
      failures++; $display("FAIL sync_aligned clk=%b tick=%b want ch0,ch3 high", clk_o, tick_o);
    end
  endtask
`endif

  task automatic test_async_reset();
    en_i = 4'b0100;
    repeat (3) step();
    reset_i = 1'b1;
    #1;
    checks++;
    if (clk_o !== 4'b0000 || tick_o !== 4'b0000) begin
      failures++; $display("FAIL async_reset clk=%b tick=%b want=0000", clk_o, tick_o);
    end
    step();
    reset_i = 1'b0;
    step();
    checks++;
    if (clk_o[2] !== 1'b0) begin
      failures++; $display("FAIL async_reset_half got=%b want=0", clk_o[2]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_default();
    test_reprogram();
    test_t0();
    test_error();
    test_enable();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
